sd_spi_responder: RTL
=====================

Name: sd_spi_responder

Overview:
- Behavioural-synthesizable SPI-mode SD card responder: the card end of the link driven by the host command/init controller.
- Deserializes 48-bit command frames from MOSI and returns R1/R7 responses on MISO.
- For CMD17, streams a data token and one block fetched from a byte-wide memory port.
- Used as an on-FPGA card stand-in for bring-up and as the DUT-side model in host-controller benches.

Parameters:
- NCR_BYTES, 1: all-ones bytes between command end bit and first response bit (1..8).
- NAC_BYTES, 1: all-ones bytes between CMD17 R1 and the data token (1..8).
- INIT_POLLS, 2: number of ACMD41 replies of 0x01 before 0x00 (0..15).
- BLOCK_BYTES, 4: supported block length in bytes (1..512).

Ports:
- clk, in, 1: SD bit clock; one MOSI bit in and one MISO bit out per cycle.
- reset, in, 1: asynchronous, active-high.
- CS, in, 1: chip select, active low.
- MOSI, in, 1: host-to-card serial data (host D1).
- MISO, out, 1: card-to-host serial data (host D0); registered.
- mem_rd, out, 1: one-cycle read strobe.
- mem_addr, out, 32: byte address for mem_rd.
- mem_rdata, in, 8: read data, valid exactly 1 cycle after mem_rd.
- card_ready, out, 1: high once ACMD41 has returned 0x00.

Behaviour:
- Reset (async): MISO=1, mem_rd=0, mem_addr=0, card_ready=0, in_idle=1, app_cmd=0, poll_cnt=0, state=HUNT.
- All serial data is MSB first. MOSI is sampled and MISO updated on posedge clk.
- CS=1 in any state: next cycle state=HUNT and MISO=1; partial frames and transfers are discarded. Card flags are kept.
- HUNT: with CS=0 and MOSI=0, capture the start bit and go to RX.
- RX: shift 47 more bits. Frame layout: [47]=0, [46]=1, [45:40]=idx, [39:8]=arg, [7:1]=crc, [0]=1.
- DECODE (1 cycle): build the response and update flags. Frame byte 5 is {frame[7:1], end bit}.
- R1 bits: [0]=in_idle, [2]=illegal, [3]=crc error, [6]=param error.
- Bad frame: bit46=0 or end bit=0 gives R1 = 0x04 | in_idle.
- CMD0: byte5 must be 0x95, else 0x08|in_idle. On a valid frame: in_idle=1, poll_cnt=0, card_ready=0, R1=0x01.
- CMD8: byte5 must be 0x87, else 0x08|in_idle. On a valid frame: R7 = R1, then {20'h0, arg[11:0]} (40 bits total).
- CMD55: R1 = in_idle; set app_cmd.
- ACMD41 (idx 41 with app_cmd=1):
  - poll_cnt < INIT_POLLS: increment poll_cnt, R1=0x01.
  - Otherwise: in_idle=0, card_ready=1, R1=0x00.
- CMD16: arg == BLOCK_BYTES gives R1=in_idle; otherwise 0x40|in_idle.
- CMD17: in_idle=1 gives R1=0x05 with no data. Otherwise R1=0x00, then a data phase at byte address arg.
- Any other idx, or idx 41 without app_cmd: R1 = 0x04 | in_idle.
- app_cmd is cleared by every decoded command except CMD55.
- NCR: drive 1 for NCR_BYTES*8 cycles.
- RESP: shift out 8 bits (R1) or 40 bits (R7).
- After RESP:
  - Non-data commands: MISO=1, go to HUNT.
  - CMD17: NAC drives 1 for NAC_BYTES*8 cycles, TOKEN sends 0xFE, DATA sends BLOCK_BYTES bytes, CRC sends 16 bits of 1, then HUNT.
- Memory fetch: mem_rd pulses with mem_addr=arg on the first TOKEN cycle.
- It pulses again with mem_addr=arg+k+1 on the first bit cycle of data byte k, for k < BLOCK_BYTES-1.
- mem_rdata is captured the following cycle into a byte buffer, then loaded into the shifter at the byte boundary.
- mem_addr wraps modulo 2^32. No bubbles between bytes.
- MOSI is ignored outside HUNT/RX. A frame starting during NCR/RESP/data is not recognised.
- Host bytes of 0xFF between frames are tolerated.
- Latency: last frame bit to first R1 bit = 1 (DECODE) + NCR_BYTES*8 cycles.

Decomposition:
- Package sd_pkg holds:
  - Command index constants: CMD0=0, CMD8=8, CMD16=16, CMD17=17, ACMD41=41, CMD55=55.
  - R1 bit positions.
  - DATA_TOKEN=8'hFE.
  - CRC constants 8'h95 / 8'h87.
  - The responder state enum: HUNT, RX, DECODE, NCR, RESP, NAC, TOKEN, DATA, CRC.
- Sub-module sd_tx_shifter: 40-bit parallel-load MSB-first serializer with load/length inputs and idle-high output. It is reused for the R1, R7, token, data and CRC phases.

Test Plan:
- CMD0 frame 40 00000000 95 with CS=0 -> after 1+8 cycles MISO sends 0x01; in_idle=1.
- CMD8 48 000001AA 87 -> R7 bytes 01 00 00 01 AA. Same frame with CRC 0x00 -> R1=0x09, no trailing 32 bits.
- CMD55+ACMD41 loop with INIT_POLLS=2 -> replies 0x01, 0x01, 0x00; card_ready rises during the third DECODE. Bare CMD41 -> 0x05.
- CMD16 arg 4 -> 0x00. Arg 8 -> 0x40.
- CMD17 arg 0x10 with memory bytes 11 22 33 44 -> R1 00, 8 ones, FE, 11 22 33 44, FFFF. mem_addr sequence 0x10..0x13, one mem_rd each. CMD17 before init -> 0x05 only.
- CS raised mid-DATA, and async reset pulsed mid-RX -> MISO=1 next cycle; a subsequent CMD0 is decoded normally.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and state encoding for the SPI-mode SD card responder.
package sd_pkg;
  localparam logic [5:0] CMD0 = 6'd0, CMD8 = 6'd8, CMD16 = 6'd16, CMD17 = 6'd17, ACMD41 = 6'd41, CMD55 = 6'd55;
  localparam int R1_IDLE = 0, R1_ILLEGAL = 2, R1_CRC = 3, R1_PARAM = 6;
  localparam logic [7:0] DATA_TOKEN = 8'hFE, CRC_CMD0 = 8'h95, CRC_CMD8 = 8'h87;
  localparam int TX_W = 40;
  typedef enum logic [3:0] {HUNT, RX, DECODE, NCR, RESP, NAC, TOKEN, DATA, CRC} state_t;
endpackage

// File: rtl/sd_tx_shifter.sv
// sd_tx_shifter: parallel-load MSB-first serializer; the first bit appears on the load edge, idles high.
module sd_tx_shifter
  import sd_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load,
  input  logic [TX_W-1:0] data,
  input  logic [5:0]      len,
  output logic            q,
  output logic            busy
);
  logic [TX_W-1:0] sr;
  logic [5:0] left;
  assign busy = left != 6'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= 1'b1;
      sr <= '1;
      left <= 6'd0;
    end else if (clr) begin
      q <= 1'b1;
      left <= 6'd0;
    end else if (load) begin
      q <= data[TX_W-1];
      sr <= {data[TX_W-2:0], 1'b1};
      left <= len - 6'd1;
    end else if (busy) begin
      q <= sr[TX_W-1];
      sr <= {sr[TX_W-2:0], 1'b1};
      left <= left - 6'd1;
    end else
      q <= 1'b1;
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: card end of an SPI-mode SD link; decodes command frames, answers R1/R7
// and streams one block from a byte-wide memory port for CMD17.
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int NCR_BYTES = 1,
  parameter int NAC_BYTES = 1,
  parameter int INIT_POLLS = 2,
  parameter int BLOCK_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        card_ready
);
  localparam logic [9:0] NCR_LAST = 10'(NCR_BYTES * 8 - 1);
  localparam logic [9:0] NAC_LAST = 10'(NAC_BYTES * 8 - 1);
  localparam logic [9:0] LAST_BYTE = 10'(BLOCK_BYTES - 1);
  localparam logic [3:0] POLLS = 4'(INIT_POLLS);
  localparam logic [31:0] BLK = 32'(BLOCK_BYTES);
  state_t state, state_nxt;
  logic [47:0] frame;
  logic [9:0] cnt, nb;
  logic [39:0] resp, ld_data;
  logic [5:0] ld_len;
  logic resp_long, resp_rd, in_idle, app_cmd, rd_q, busy, ld;
  logic [3:0] poll_cnt;
  logic [7:0] byte_buf;
  logic [5:0] idx;
  logic [31:0] arg;
  logic [7:0] r1;
  logic [31:0] r7;
  logic long_d, rd_d, app_d, idle_d, ready_d;
  logic [3:0] poll_d;
  assign idx = frame[45:40];
  assign arg = frame[39:8];
  assign nb = (state == TOKEN) ? 10'd0 : cnt + 10'd1;
  always_comb begin
    r1 = 8'h00;
    r1[R1_IDLE] = in_idle;
    r7 = 32'h0;
    long_d = 1'b0;
    rd_d = 1'b0;
    app_d = 1'b0;
    idle_d = in_idle;
    ready_d = card_ready;
    poll_d = poll_cnt;
    if (frame[47] || !frame[46] || !frame[0])
      r1[R1_ILLEGAL] = 1'b1;
    else if (idx == CMD0) begin
      if (frame[7:0] != CRC_CMD0)
        r1[R1_CRC] = 1'b1;
      else begin
        r1 = 8'h01;
        idle_d = 1'b1;
        poll_d = 4'd0;
        ready_d = 1'b0;
      end
    end else if (idx == CMD8) begin
      if (frame[7:0] != CRC_CMD8)
        r1[R1_CRC] = 1'b1;
      else begin
        long_d = 1'b1;
        r7 = {20'h0, arg[11:0]};
      end
    end else if (idx == CMD55)
      app_d = 1'b1;
    else if (idx == ACMD41 && app_cmd) begin
      if (poll_cnt < POLLS) begin
        poll_d = poll_cnt + 4'd1;
        r1 = 8'h01;
      end else begin
        r1 = 8'h00;
        idle_d = 1'b0;
        ready_d = 1'b1;
      end
    end else if (idx == CMD16)
      r1[R1_PARAM] = arg != BLK;
    else if (idx == CMD17) begin
      r1 = in_idle ? 8'h05 : 8'h00;
      rd_d = !in_idle;
    end else
      r1[R1_ILLEGAL] = 1'b1;
  end
  always_comb begin
    state_nxt = state;
    ld = 1'b0;
    ld_data = {byte_buf, 32'h0};
    ld_len = 6'd8;
    if (CS)
      state_nxt = HUNT;
    else
      case (state)
        HUNT: state_nxt = MOSI ? HUNT : RX;
        RX: state_nxt = (cnt == 10'd46) ? DECODE : RX;
        DECODE: state_nxt = NCR;
        NCR: if (cnt == NCR_LAST) begin
          state_nxt = RESP;
          ld = 1'b1;
          ld_data = resp;
          ld_len = resp_long ? 6'd40 : 6'd8;
        end
        RESP: if (!busy) state_nxt = resp_rd ? NAC : HUNT;
        NAC: if (cnt == NAC_LAST) begin
          state_nxt = TOKEN;
          ld = 1'b1;
          ld_data = {DATA_TOKEN, 32'h0};
        end
        TOKEN: if (!busy) begin
          state_nxt = DATA;
          ld = 1'b1;
        end
        DATA: if (!busy) begin
          ld = 1'b1;
          if (cnt == LAST_BYTE) begin
            state_nxt = CRC;
            ld_data = {16'hFFFF, 24'h0};
            ld_len = 6'd16;
          end
        end
        CRC: state_nxt = busy ? CRC : HUNT;
        default: state_nxt = HUNT;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HUNT;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      frame <= '0;
      cnt <= 10'd0;
      resp <= '0;
      resp_long <= 1'b0;
      resp_rd <= 1'b0;
      in_idle <= 1'b1;
      app_cmd <= 1'b0;
      poll_cnt <= 4'd0;
      card_ready <= 1'b0;
      mem_rd <= 1'b0;
      mem_addr <= 32'h0;
      byte_buf <= 8'hFF;
      rd_q <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      rd_q <= mem_rd;
      if (rd_q) byte_buf <= mem_rdata;
      if (state == HUNT || state == RX) frame <= {frame[46:0], MOSI};
      cnt <= (state == RX || state == NCR || state == NAC || (state == DATA && !busy)) ? cnt + 10'd1 :
             (state == DATA) ? cnt : 10'd0;
      if (state == DECODE && !CS) begin
        resp <= {r1, r7};
        resp_long <= long_d;
        resp_rd <= rd_d;
        in_idle <= idle_d;
        app_cmd <= app_d;
        poll_cnt <= poll_d;
        card_ready <= ready_d;
      end
      // block fetch runs one byte ahead of the shifter so bytes go out back to back
      if (ld && state == NAC) begin
        mem_rd <= 1'b1;
        mem_addr <= arg;
      end else if (ld && state_nxt == DATA && nb < LAST_BYTE) begin
        mem_rd <= 1'b1;
        mem_addr <= mem_addr + 32'd1;
      end
    end
  sd_tx_shifter u_tx (
    .clk(clk),
    .reset(reset),
    .clr(CS),
    .load(ld),
    .data(ld_data),
    .len(ld_len),
    .q(MISO),
    .busy(busy)
  );
endmodule
